c432_resp_monitor: RTL and testbench

Downstream response monitor for the pipelined c432 core. Tracks which cycles carry valid results through the core's fixed pipeline latency, compacts each valid 7-bit response into a 16-bit MISR signature, counts responses, and flags pass/fail against an expected signature once the programmed vector run has drained. Sits directly on the core's output bus and replaces per-vector printing in regression.

---
 rtl/c432_mon_pkg.sv | 26 ++
 rtl/c432_misr.sv | 34 +++
 rtl/c432_resp_monitor.sv | 130 +++++++++++++
 tb/tb_c432_resp_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/c432_mon_pkg.sv
// Shared widths, MISR constants and monitor state type for the c432 response monitor.
package c432_mon_pkg;

  localparam int unsigned SIG_W     = 16;
  localparam int unsigned OUT_W     = 7;
  localparam int unsigned CAP_DEPTH = 8;

  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } mon_state_t;

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic [OUT_W-1:0] d);
    logic [SIG_W-1:0] t;
    t = {s[SIG_W-2:0], 1'b0};
    if (s[SIG_W-1]) t = t ^ MISR_POLY;
    return t ^ {{(SIG_W-OUT_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/c432_misr.sv
// 16-bit MISR: seed load takes priority over folding one response word.
module c432_misr
  import c432_mon_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic             fold_en,
  input  logic [OUT_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_d, sig_q;

  always_comb begin
    sig_d = sig_q;
    if (seed_load) begin
      sig_d = MISR_SEED;
    end else if (fold_en) begin
      sig_d = misr_next(sig_q, data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/c432_resp_monitor.sv
// Response monitor: valid delay line, MISR compaction, run FSM and pass verdict.
// Optional capture of the first 8 folded responses when C432_MON_CAPTURE_EN is defined.
module c432_resp_monitor
  import c432_mon_pkg::*;
#(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned NVEC    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [OUT_W-1:0] outz,
  input  logic [SIG_W-1:0] exp_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [7:0]       vec_cnt,
  input  logic [2:0]       cap_addr,
  output logic [OUT_W-1:0] cap_data
);

  localparam logic [7:0] NvecCnt = 8'(NVEC);

  mon_state_t         state_q, state_d;
  logic [7:0]         acc_cnt_q, acc_cnt_d;
  logic [7:0]         vec_cnt_q, vec_cnt_d;
  logic [LATENCY-1:0] dly_q, dly_d;
  logic [LATENCY:0]   dly_shift;
  logic               pass_q, pass_d;
  logic               start_run, accept, fold;

  // Top bit of the shifted view is the delay-line tail.
  assign dly_shift = {dly_q, accept};
  assign start_run = start && ((state_q == StIdle) || (state_q == StDone));
  assign accept    = in_valid && (state_q == StRun) && (acc_cnt_q < NvecCnt);
  assign fold      = dly_shift[LATENCY] && ((state_q == StRun) || (state_q == StDrain));

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    vec_cnt_d = vec_cnt_q;
    pass_d    = pass_q;
    dly_d     = dly_shift[LATENCY-1:0];
    if (fold) vec_cnt_d = vec_cnt_q + 8'd1;
    if (accept) acc_cnt_d = acc_cnt_q + 8'd1;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_run) begin
          state_d   = StRun;
          acc_cnt_d = '0;
          vec_cnt_d = '0;
          dly_d     = '0;
          pass_d    = 1'b0;
        end
      end
      StRun: begin
        if (accept && (acc_cnt_q == NvecCnt - 8'd1)) state_d = StDrain;
      end
      StDrain: begin
        if ((dly_q == '0) && (vec_cnt_q == NvecCnt)) begin
          state_d = StDone;
          pass_d  = (sig == exp_sig);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_cnt_q <= '0;
      vec_cnt_q <= '0;
      dly_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      dly_q     <= dly_d;
      pass_q    <= pass_d;
    end
  end

  c432_misr u_misr (
    .clk       (clk),
    .rst       (rst),
    .seed_load (start_run),
    .fold_en   (fold),
    .data      (outz),
    .sig       (sig)
  );

`ifdef C432_MON_CAPTURE_EN
  logic [OUT_W-1:0] cap_q [CAP_DEPTH];
  logic [OUT_W-1:0] cap_d [CAP_DEPTH];

  // Slot index is the response count before this fold.
  always_comb begin
    cap_d = cap_q;
    if (start_run) begin
      for (int i = 0; i < CAP_DEPTH; i++) cap_d[i] = '0;
    end else if (fold && (vec_cnt_q < 8'(CAP_DEPTH))) begin
      cap_d[vec_cnt_q[2:0]] = outz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CAP_DEPTH; i++) cap_q[i] <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign cap_data = cap_q[cap_addr];
`else
  logic unused_cap_addr;
  assign unused_cap_addr = ^cap_addr;
  assign cap_data        = '0;
`endif

  assign busy    = (state_q == StRun) || (state_q == StDrain);
  assign done    = (state_q == StDone);
  assign pass    = pass_q;
  assign vec_cnt = vec_cnt_q;

endmodule

// File: tb/tb_c432_resp_monitor.sv
// Randomized bench for c432_resp_monitor against a queue-based response model.
module tb_c432_resp_monitor;

  localparam int LATENCY = 3;
  localparam int NVEC    = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [6:0]  outz = '0;
  logic [15:0] exp_sig = '0;
  logic        busy, done, pass;
  logic [15:0] sig;
  logic [7:0]  vec_cnt;
  logic [2:0]  cap_addr = '0;
  logic [6:0]  cap_data;

  c432_resp_monitor #(.LATENCY(LATENCY), .NVEC(NVEC)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .outz     (outz),
    .exp_sig  (exp_sig),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .sig      (sig),
    .vec_cnt  (vec_cnt),
    .cap_addr (cap_addr),
    .cap_data (cap_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sw_misr(input logic [15:0] s, input logic [6:0] d);
    logic [15:0] t;
    t = s << 1;
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {9'd0, d};
  endfunction

  // Behavioural model: accepted vectors schedule a fold at acceptance time + LATENCY.
  int          cyc = 0;
  int          due[$];
  bit          m_act, m_done, m_pass;
  logic [15:0] m_sig;
  int          m_acc, m_folded;
  logic [6:0]  m_cap [8];
  bit          busy_pre;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_done = 0; m_pass = 0; m_sig = '0; m_acc = 0; m_folded = 0;
      due.delete();
      for (int i = 0; i < 8; i++) m_cap[i] = '0;
    end else begin
      cyc++;
      busy_pre = m_act && !m_done;
      if (busy_pre && m_folded == NVEC && due.size() == 0) begin
        m_done = 1;
        m_pass = (m_sig == exp_sig);
      end else if (busy_pre) begin
        if (due.size() > 0 && due[0] == cyc) begin
          void'(due.pop_front());
          if (m_folded < 8) m_cap[m_folded] = outz;
          m_sig = sw_misr(m_sig, outz);
          m_folded++;
        end
        if (in_valid && m_acc < NVEC) begin
          due.push_back(cyc + LATENCY);
          m_acc++;
        end
      end else if (start) begin
        m_act = 1; m_done = 0; m_pass = 0; m_sig = 16'hFFFF; m_acc = 0; m_folded = 0;
        due.delete();
        for (int i = 0; i < 8; i++) m_cap[i] = '0;
      end
    end
  end

  bit chk_en = 1'b1;
  logic [6:0] exp_cap;

  always @(negedge clk) begin
    if (chk_en) begin
      #2;
`ifdef C432_MON_CAPTURE_EN
      exp_cap = m_cap[cap_addr];
`else
      exp_cap = '0;
`endif
      chk("busy", 16'(busy), 16'(m_act && !m_done));
      chk("done", 16'(done), 16'(m_done));
      if (m_done) chk("pass", 16'(pass), 16'(m_pass));
      chk("sig", sig, m_sig);
      chk("vec_cnt", 16'(vec_cnt), 16'(m_folded));
      chk("cap_data", 16'(cap_data), 16'(exp_cap));
    end
  end

  // Directed runs feed a fixed response table indexed by the model's fold count.
  logic [6:0]  resp_tab [NVEC];
  bit          resp_mode = 1'b0;
  bit          cap_rand = 1'b1;
  logic [15:0] golden;

  always @(negedge clk) begin
    if (cap_rand) cap_addr = 3'($urandom);
    if (resp_mode) outz = resp_tab[(m_folded < NVEC) ? m_folded : 0];
  end

  function automatic logic [15:0] golden_sig();
    logic [15:0] g;
    g = 16'hFFFF;
    for (int i = 0; i < NVEC; i++) g = sw_misr(g, resp_tab[i]);
    return g;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_done"}, 16'(done), 16'd0);
    chk({tag, "_pass"}, 16'(pass), 16'd0);
    chk({tag, "_sig"}, sig, 16'h0000);
    chk({tag, "_vec_cnt"}, 16'(vec_cnt), 16'd0);
    chk({tag, "_cap_data"}, 16'(cap_data), 16'd0);
  endtask

  task automatic run_b2b(input logic [15:0] e, input logic exp_pass, input int abort_k,
                         input bit pin_first);
    int k_done;
    k_done = -1;
    @(negedge clk);
    exp_sig = e; start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      in_valid = (k <= NVEC);
      @(negedge clk);
      if (pin_first && k == LATENCY + 1) chk("first_fold_sig", sig, 16'hEFDF);
      if (k == abort_k) begin
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk_reset_vals("rst_drain");
        return;
      end
      if (done) begin
        k_done = k;
        break;
      end
    end
    in_valid = 1'b0;
    chk("done_edge", 16'(k_done), 16'(NVEC + LATENCY + 1));
    chk("b2b_vec_cnt", 16'(vec_cnt), 16'(NVEC));
    chk("b2b_sig", sig, golden_sig());
    chk("b2b_pass", 16'(pass), 16'(exp_pass));
  endtask

  task automatic run_gapped();
    int pulses;
    bit seen;
    pulses = 0;
    seen = 0;
    @(negedge clk);
    exp_sig = golden_sig(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      in_valid = (pulses < NVEC) ? (k % 3 == 1) : (pulses < NVEC + 3);
      if (in_valid) pulses++;
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    in_valid = 1'b0;
    chk("gap_done_seen", 16'(seen), 16'd1);
    chk("gap_vec_cnt", 16'(vec_cnt), 16'(NVEC));
    chk("gap_sig", sig, golden_sig());
    chk("gap_pass", 16'(pass), 16'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NVEC; i++) resp_tab[i] = (i == 0) ? 7'h00 : 7'((i * 13 + 5) % 128);
    golden = golden_sig();

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outz = 7'($urandom);
      #1;
      chk_reset_vals("in_reset");
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      outz = 7'($urandom);
      #1;
      chk("idle_busy", 16'(busy), 16'd0);
      chk("idle_sig", sig, 16'h0000);
    end

    resp_mode = 1'b1;
    run_b2b(golden, 1'b1, 0, 1'b1);
    run_b2b(golden ^ 16'h0001, 1'b0, 0, 1'b1);
    run_gapped();
    run_b2b(golden, 1'b1, NVEC + 1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    run_b2b(golden, 1'b1, 0, 1'b1);

    // Capture contents after folding 7'h01..7'h0A.
    for (int i = 0; i < NVEC; i++) resp_tab[i] = 7'(i + 1);
    run_b2b(golden_sig(), 1'b1, 0, 1'b0);
    @(negedge clk);
    cap_rand = 1'b0;
    for (int a = 0; a < 8; a++) begin
      cap_addr = 3'(a);
      #1;
`ifdef C432_MON_CAPTURE_EN
      chk("cap_read", 16'(cap_data), 16'(a + 1));
`else
      chk("cap_read", 16'(cap_data), 16'd0);
`endif
    end
    cap_rand = 1'b1;
    resp_mode = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      outz     = 7'($urandom);
      in_valid = ($urandom_range(2, 0) != 0);
      start    = ($urandom_range(15, 0) == 0);
      exp_sig  = $urandom_range(1, 0) ? m_sig : 16'($urandom);
      rst      = ($urandom_range(399, 0) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
